// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ovs
// Purpose  : Oversampled 8N1 UART receiver. Double-flops the asynchronous rx
//            pin, detects the start bit, and majority-votes three samples
//            around mid-bit. A good byte is presented with a one-cycle
//            rx_ready strobe. A rejected frame gives a one-cycle rx_err strobe.
// Ports    : clk      - single clock, rising edge
//            rst      - synchronous reset, active-high
//            rx       - asynchronous serial line, idle high
//            rx_data  - last good byte, held until the next good frame
//            rx_ready - one-cycle strobe, rx_data updated this cycle
//            rx_err   - one-cycle strobe, frame rejected (bad stop/parity)
// Config   : UART_RX_PARITY_EN - when defined, a parity bit follows the data
//            bits and is checked against PARITY_ODD.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ovs #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              rx_err
);

    localparam int c_CW = $clog2(CLKS_PER_BIT + 1);
    localparam int c_IW = $clog2(DATA_W + 1);

    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic [c_CW-1:0] c_HM1      = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_H        = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_CW-1:0] c_HP1      = c_CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_LAST_BIT = c_IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [c_CW-1:0]   r_cnt_q,   w_cnt_d;
    logic [c_IW-1:0]   r_idx_q,   w_idx_d;
    logic [DATA_W-1:0] r_shift_q, w_shift_d;
    logic [DATA_W-1:0] r_data_q,  w_data_d;
    logic [1:0]        r_samp_q,  w_samp_d;
    logic              r_ready_q, w_ready_d;
    logic              r_err_q,   w_err_d;
    logic              r_s1_q,    w_s1_d;
    logic              r_s2_q,    w_s2_d;

    logic w_rx_s;
    logic w_maj;
    logic w_par_ok;

    assign w_s1_d = rx;
    assign w_s2_d = r_s1_q;
    assign w_rx_s = r_s2_q;

    // Two samples are stored at H-1 and H; the third is the live line at H+1.
    assign w_maj = (r_samp_q[0] & r_samp_q[1]) |
                   (r_samp_q[0] & w_rx_s)      |
                   (r_samp_q[1] & w_rx_s);

`ifdef UART_RX_PARITY_EN
    localparam logic c_ODD = (PARITY_ODD != 0);

    logic r_par_q, w_par_d;

    // Total ones over data plus parity bit must match the configured sense.
    assign w_par_ok = (((^r_shift_q) ^ r_par_q) == c_ODD);
`else
    logic w_unused_parity_cfg;

    assign w_unused_parity_cfg = (PARITY_ODD != 0);
    assign w_par_ok            = 1'b1;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = (r_cnt_q == c_LAST) ? '0 : r_cnt_q + c_ONE;
        w_idx_d   = r_idx_q;
        w_shift_d = r_shift_q;
        w_data_d  = r_data_q;
        w_samp_d  = r_samp_q;
        w_ready_d = 1'b0;
        w_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_d   = r_par_q;
`endif

        if (r_cnt_q == c_HM1) w_samp_d[0] = w_rx_s;
        if (r_cnt_q == c_H)   w_samp_d[1] = w_rx_s;

        case (r_state_q)
            ST_IDLE: begin
                w_cnt_d = '0;
                // The cycle that first sees the line low is tick 0 of the
                // start bit, so the timer continues from 1.
                if (!w_rx_s) begin
                    w_state_d = ST_START;
                    w_cnt_d   = c_ONE;
                end
            end
            ST_START: begin
                if ((r_cnt_q == c_HP1) && w_maj) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_LAST) begin
                    w_state_d = ST_DATA;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (r_cnt_q == c_HP1) begin
                    w_shift_d             = r_shift_q >> 1;
                    w_shift_d[DATA_W-1]   = w_maj;
                end
                if (r_cnt_q == c_LAST) begin
                    w_cnt_d = '0;
                    if (r_idx_q == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = ST_PARITY;
`else
                        w_state_d = ST_STOP;
`endif
                    end else begin
                        w_idx_d = r_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt_q == c_HP1) w_par_d = w_maj;
                if (r_cnt_q == c_LAST) begin
                    w_state_d = ST_STOP;
                    w_cnt_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid stop bit so the next start edge is caught early.
                if (r_cnt_q == c_HP1) begin
                    w_cnt_d = '0;
                    if (!w_maj) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_BREAK;
                    end else if (w_par_ok) begin
                        w_data_d  = r_shift_q;
                        w_ready_d = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_d = '0;
                if (w_rx_s) w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_q    <= 1'b1;
            r_s2_q    <= 1'b1;
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_shift_q <= '0;
            r_data_q  <= '0;
            r_samp_q  <= 2'b11;
            r_ready_q <= 1'b0;
            r_err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_s1_q    <= w_s1_d;
            r_s2_q    <= w_s2_d;
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_shift_q <= w_shift_d;
            r_data_q  <= w_data_d;
            r_samp_q  <= w_samp_d;
            r_ready_q <= w_ready_d;
            r_err_q   <= w_err_d;
`ifdef UART_RX_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    assign rx_data  = r_data_q;
    assign rx_ready = r_ready_q;
    assign rx_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ovs
// Purpose  : Self-checking bench for uart_rx_ovs. A serial driver builds
//            frames from bytes; a frame-level model predicts, per frame, the
//            cycle and kind of the resulting strobe, and a per-cycle compare
//            checks rx_ready, rx_err and rx_data against it. A few literal
//            checks pin the model (latency, data order, error counts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ovs;

    localparam int CPB  = 16;
    localparam int DW   = 8;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Strobe edge after e0: sync (2) + whole bits before stop + mid-bit + 1.
    localparam int LAT = 2 + (1 + DW + P) * CPB + CPB / 2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic          rx_err;

    uart_rx_ovs #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .PARITY_ODD   (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_err   (rx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        bit            err;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW-1:0] model_data;
    int            cyc     = 0;
    bit            chk_en  = 1'b0;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            n_ready = 0;
    int            n_err   = 0;
    int            last_ready_cyc = -1;
    logic [DW-1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_r;
            bit exp_e;
            exp_r = 1'b0;
            exp_e = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_r = !exp_q[0].err;
                exp_e = exp_q[0].err;
                if (!exp_q[0].err) model_data = exp_q[0].data;
                exp_q.delete(0);
            end
            n_cmp++;
            if ({rx_ready, rx_err, rx_data} !== {exp_r, exp_e, model_data}) begin
                n_bad++;
                $display("FAIL cycle %0d: ready/err/data got %b/%b/%h expected %b/%b/%h",
                         cyc, rx_ready, rx_err, rx_data, exp_r, exp_e, model_data);
            end
        end
    end

    // Strobe observer for literal checks.
    always @(negedge clk) begin
        if (chk_en && rx_ready === 1'b1) begin
            n_ready++;
            last_ready_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (chk_en && rx_err === 1'b1) n_err++;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now (just after a rising edge) and registers
    // its expected outcome: the next edge is e0, the strobe appears LAT later.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit,
                              input bit par_bad, input int extra_low);
        ev_t ev;
        ev.cyc  = cyc + 1 + LAT;
        ev.err  = !stop_bit || par_bad;
        ev.data = d;
        exp_q.push_back(ev);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            idle(CPB);
        end
        if (P == 1) begin
            rx = (^d) ^ PODD ^ par_bad;
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        if (!stop_bit) begin
            idle(extra_low);
            rx = 1'b1;
            idle(CPB);
        end
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        idle(len);
        rx = 1'b1;
        idle(CPB + 14);
    endtask

    // Start a frame, then reset partway through it; nothing may be reported.
    task automatic reset_mid_frame(input int bits, input int part);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < bits; i++) begin
            rx = 1'($urandom_range(0, 1));
            idle(CPB);
        end
        idle(part);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        model_data = '0;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        idle(CPB);
    endtask

    initial begin
        int c0;
        int nr;
        int ne;
        rst        = 1'b1;
        rx         = 1'b1;
        model_data = '0;

        // 1: reset held three edges, then a long idle with no strobes.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(500);
        check("idle_ready_count", n_ready, 0);
        check("idle_err_count", n_err, 0);

        // 2: single frame, latency pinned to a literal.
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("a5_latency", last_ready_cyc - (c0 + 1), (P == 1) ? 171 : 155);
        check("a5_data", int'(rx_data), 8'hA5);
        check("a5_err_count", n_err, 0);

        // 3: back-to-back frames.
        idle(7);
        nr = n_ready;
        got_q.delete();
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        check("b2b_count", n_ready - nr, 3);
        check("b2b_byte0", (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h00);
        check("b2b_byte1", (got_q.size() > 1) ? int'(got_q[1]) : -1, 8'hFF);
        check("b2b_byte2", (got_q.size() > 2) ? int'(got_q[2]) : -1, 8'h3C);

        // 4: short glitch ignored, next frame intact.
        idle(20);
        nr = n_ready;
        ne = n_err;
        glitch(4);
        check("glitch_ready", n_ready - nr, 0);
        check("glitch_err", n_err - ne, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        check("after_glitch_data", int'(rx_data), 8'h5A);

        // 5: stop bit low then a held-low line: one error, data held.
        ne = n_err;
        send_frame(8'h81, 1'b0, 1'b0, 100);
        check("break_err_count", n_err - ne, 1);
        check("break_data_held", int'(rx_data), 8'h5A);
        send_frame(8'h42, 1'b1, 1'b0, 0);
        check("after_break_data", int'(rx_data), 8'h42);

`ifdef UART_RX_PARITY_EN
        // 6: parity accepted and rejected.
        idle(10);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        check("par_ok_data", int'(rx_data), 8'h07);
        ne = n_err;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        check("par_bad_err", n_err - ne, 1);
        check("par_bad_data_held", int'(rx_data), 8'h07);
`endif

        // Reset in the middle of a byte: silent abort, data cleared.
        nr = n_ready;
        ne = n_err;
        reset_mid_frame(3, 5);
        check("rst_mid_ready", n_ready - nr, 0);
        check("rst_mid_err", n_err - ne, 0);
        check("rst_mid_data", int'(rx_data), 0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                glitch(int'($urandom_range(1, CPB / 2 - 1)));
            end else if (kind == 1) begin
                send_frame(8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 60)));
            end else if (kind == 2) begin
                reset_mid_frame(int'($urandom_range(0, DW - 1)),
                                int'($urandom_range(0, CPB - 1)));
            end else if (kind == 3 && P == 1) begin
                send_frame(8'($urandom), 1'b1, 1'b1, 0);
            end else begin
                send_frame(8'($urandom), 1'b1, 1'b0, 0);
            end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 40)));
        end

        idle(200);
        check("model_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
